// File: rtl/clock_set_controller.sv
// Time-setting sequencer for the 24-hour clock. It turns debounced MODE/UP buttons into
// a field-select state, increment/clear strobes and a per-digit blink mask.
module clock_set_controller #(
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int BLINK_TICKS  = 4,
  parameter int TIMEOUT_S    = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEC_TICK,
  input  logic       FAST_TICK,
  input  logic       MODE_BUTTON,
  input  logic       UP_BUTTON,
  output logic       RUN_EN,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       CLEAR_SEC,
  output logic [1:0] SET_MODE,
  output logic [3:0] BLANK
);

  localparam int HOLD_W   = $clog2(HOLD_TICKS + 1);
  localparam int REPEAT_W = $clog2(REPEAT_TICKS + 1);
  localparam int BLINK_W  = $clog2(BLINK_TICKS + 1);
  localparam int IDLE_W   = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    STATE_RUN      = 2'b00,
    STATE_SET_HOUR = 2'b01,
    STATE_SET_MIN  = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic modeBtn_q, upBtn_q;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic [REPEAT_W-1:0] repCnt_q, repCnt_d;
  logic [BLINK_W-1:0]  blinkCnt_q, blinkCnt_d;
  logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
  logic phase_q, phase_d;
  logic incHour_q, incHour_d;
  logic incMin_q, incMin_d;
  logic clearSec_q, clearSec_d;

  logic riseMode, riseUp, inSet, timeout, stateChange, enterSet;
  logic repeatHit, incPulse, blinkWrap;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= STATE_RUN;
      modeBtn_q  <= 1'b1;
      upBtn_q    <= 1'b1;
      holdCnt_q  <= '0;
      repCnt_q   <= '0;
      blinkCnt_q <= '0;
      idleCnt_q  <= '0;
      phase_q    <= 1'b0;
      incHour_q  <= 1'b0;
      incMin_q   <= 1'b0;
      clearSec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      modeBtn_q  <= MODE_BUTTON;
      upBtn_q    <= UP_BUTTON;
      holdCnt_q  <= holdCnt_d;
      repCnt_q   <= repCnt_d;
      blinkCnt_q <= blinkCnt_d;
      idleCnt_q  <= idleCnt_d;
      phase_q    <= phase_d;
      incHour_q  <= incHour_d;
      incMin_q   <= incMin_d;
      clearSec_q <= clearSec_d;
    end
  end

  always_comb begin
    riseMode    = MODE_BUTTON & ~modeBtn_q;
    riseUp      = UP_BUTTON & ~upBtn_q;
    inSet       = (state_q != STATE_RUN);
    timeout     = inSet && (idleCnt_q == IDLE_W'(TIMEOUT_S));
    state_d     = state_q;
    clearSec_d  = 1'b0;
    holdCnt_d   = '0;
    repCnt_d    = '0;
    repeatHit   = 1'b0;
    blinkCnt_d  = blinkCnt_q;
    phase_d     = phase_q;
    idleCnt_d   = idleCnt_q;
    blinkWrap   = FAST_TICK && (blinkCnt_q == BLINK_W'(BLINK_TICKS - 1));

    // A MODE edge always beats a simultaneous timeout or UP edge.
    if (riseMode) begin
      case (state_q)
        STATE_RUN:      state_d = STATE_SET_HOUR;
        STATE_SET_HOUR: state_d = STATE_SET_MIN;
        default: begin
          state_d    = STATE_RUN;
          clearSec_d = 1'b1;
        end
      endcase
    end else if (timeout) begin
      state_d = STATE_RUN;
    end

    stateChange = (state_d != state_q);
    enterSet    = stateChange && (state_d != STATE_RUN);

    // Auto-repeat: hold phase saturates at HOLD_TICKS, then the repeat counter takes over.
    if (inSet && !stateChange && UP_BUTTON) begin
      holdCnt_d = holdCnt_q;
      repCnt_d  = repCnt_q;
      if (FAST_TICK) begin
        if (holdCnt_q != HOLD_W'(HOLD_TICKS)) begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
          repeatHit = (holdCnt_q == HOLD_W'(HOLD_TICKS - 1));
        end else if (repCnt_q == REPEAT_W'(REPEAT_TICKS - 1)) begin
          repCnt_d  = '0;
          repeatHit = 1'b1;
        end else begin
          repCnt_d = repCnt_q + REPEAT_W'(1);
        end
      end
    end

    incPulse  = inSet && !stateChange && (riseUp || repeatHit);
    incHour_d = incPulse && (state_q == STATE_SET_HOUR);
    incMin_d  = incPulse && (state_q == STATE_SET_MIN);

    if (!inSet || stateChange || incPulse) begin
      idleCnt_d = '0;
    end else if (SEC_TICK && (idleCnt_q != IDLE_W'(TIMEOUT_S))) begin
      idleCnt_d = idleCnt_q + IDLE_W'(1);
    end

    // Keep the field steady while the user is actively adjusting it.
    if (enterSet) begin
      blinkCnt_d = '0;
      phase_d    = 1'b0;
    end else begin
      if (FAST_TICK) begin
        blinkCnt_d = blinkWrap ? '0 : blinkCnt_q + BLINK_W'(1);
        phase_d    = blinkWrap ? ~phase_q : phase_q;
      end
      if (UP_BUTTON) begin
        phase_d = 1'b0;
      end
    end
  end

  always_comb begin
    case (state_q)
      STATE_SET_HOUR: BLANK = {phase_q, phase_q, 2'b00};
      STATE_SET_MIN:  BLANK = {2'b00, phase_q, phase_q};
      default:        BLANK = 4'b0000;
    endcase
  end

  assign RUN_EN    = (state_q == STATE_RUN);
  assign SET_MODE  = state_q;
  assign INC_HOUR  = incHour_q;
  assign INC_MIN   = incMin_q;
  assign CLEAR_SEC = clearSec_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: a cycle model built from the behavioural rules
// plus literal checks at the key points of each scenario.
module tb_clock_set_controller;

  localparam int HOLD    = 8;
  localparam int REPEAT  = 2;
  localparam int BLINK   = 4;
  localparam int TIMEOUT = 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEC_TICK = 1'b0;
  logic       FAST_TICK = 1'b0;
  logic       MODE_BUTTON = 1'b1;
  logic       UP_BUTTON = 1'b0;
  logic       RUN_EN, INC_HOUR, INC_MIN, CLEAR_SEC;
  logic [1:0] SET_MODE;
  logic [3:0] BLANK;
  logic [9:0] dutVec;

  int vectors = 0;
  int miscompares = 0;
  int incHourCnt = 0, incMinCnt = 0, clearCnt = 0, clearNoRun = 0;
  int snapH, snapM, snapC;

  // Model state: field index 0/1/2, seconds idle, FAST ticks while held, FAST ticks since entry.
  int mMode = 0, mIdle = 0, mHeld = 0, mFast = 0, mNext = 0;
  bit mPh = 0, mPrevM = 1, mPrevU = 1, eIncH = 0, eIncM = 0, eClr = 0;
  bit rM, rU, tOut, hit, pulse;

  clock_set_controller #(
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REPEAT), .BLINK_TICKS(BLINK), .TIMEOUT_S(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SEC_TICK(SEC_TICK), .FAST_TICK(FAST_TICK),
    .MODE_BUTTON(MODE_BUTTON), .UP_BUTTON(UP_BUTTON), .RUN_EN(RUN_EN),
    .INC_HOUR(INC_HOUR), .INC_MIN(INC_MIN), .CLEAR_SEC(CLEAR_SEC),
    .SET_MODE(SET_MODE), .BLANK(BLANK)
  );

  assign dutVec = {RUN_EN, INC_HOUR, INC_MIN, CLEAR_SEC, SET_MODE, BLANK};

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mMode = 0; mIdle = 0; mHeld = 0; mFast = 0; mPh = 0;
      mPrevM = 1; mPrevU = 1; eIncH = 0; eIncM = 0; eClr = 0;
    end else begin
      rM = MODE_BUTTON && !mPrevM;
      rU = UP_BUTTON && !mPrevU;
      mPrevM = MODE_BUTTON;
      mPrevU = UP_BUTTON;
      tOut = (mMode != 0) && (mIdle >= TIMEOUT);
      if (rM) mNext = (mMode + 1) % 3;
      else if (tOut) mNext = 0;
      else mNext = mMode;
      eClr = rM && (mMode == 2);
      hit = 0;
      if (mNext != mMode || mMode == 0 || !UP_BUTTON) mHeld = 0;
      else if (FAST_TICK) begin
        mHeld++;
        hit = (mHeld == HOLD) || (mHeld > HOLD && (mHeld - HOLD) % REPEAT == 0);
      end
      pulse = (mNext == mMode) && (mMode != 0) && (rU || hit);
      eIncH = pulse && (mMode == 1);
      eIncM = pulse && (mMode == 2);
      if (mNext != mMode || mMode == 0 || pulse) mIdle = 0;
      else if (SEC_TICK && mIdle < TIMEOUT) mIdle++;
      if (mNext != 0 && mNext != mMode) begin
        mFast = 0;
        mPh = 0;
      end else begin
        if (FAST_TICK) begin
          mFast++;
          if (mFast % BLINK == 0) mPh = !mPh;
        end
        if (UP_BUTTON) mPh = 0;
      end
      mMode = mNext;
    end
  end

  function automatic logic [9:0] expVec();
    logic [1:0] m;
    logic [3:0] b;
    m = 2'(mMode);
    b = (mMode == 1) ? {mPh, mPh, 2'b00} : (mMode == 2) ? {2'b00, mPh, mPh} : 4'b0000;
    return {mMode == 0, eIncH, eIncM, eClr, m, b};
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    checkOutput("cycle", dutVec, expVec());
    if (INC_HOUR === 1'b1) incHourCnt++;
    if (INC_MIN === 1'b1) incMinCnt++;
    if (CLEAR_SEC === 1'b1) clearCnt++;
    if (CLEAR_SEC === 1'b1 && RUN_EN !== 1'b1) clearNoRun++;
  endtask

  task automatic applyStimulus(input logic m, input logic u, input logic s, input logic f,
                               input int n);
    MODE_BUTTON = m;
    UP_BUTTON   = u;
    SEC_TICK    = s;
    FAST_TICK   = f;
    repeat (n) step();
  endtask

  task automatic pressMode();
    applyStimulus(1, 0, 0, 0, 5);
    applyStimulus(0, 0, 0, 0, 15);
  endtask

  task automatic snap();
    snapH = incHourCnt;
    snapM = incMinCnt;
    snapC = clearCnt;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("resetState", dutVec, 10'b1_000_00_0000);
    RESET = 1'b1;
    applyStimulus(1, 0, 0, 0, 5);
    checkOutput("heldModeNoEdge", dutVec, 10'b1_000_00_0000);
    applyStimulus(0, 0, 0, 0, 20);

    snap();
    pressMode();
    checkOutput("press1SetHour", {8'd0, RUN_EN, 1'b0}, {8'd0, 1'b0, 1'b0});
    checkOutput("press1Mode", {8'd0, SET_MODE}, 10'd1);
    pressMode();
    checkOutput("press2Mode", {8'd0, SET_MODE}, 10'd2);
    pressMode();
    checkOutput("press3Mode", {7'd0, RUN_EN, SET_MODE}, 10'b100);
    checkOutput("clearSecPulses", 10'(clearCnt - snapC), 10'd1);

    pressMode();
    pressMode();
    snap();
    repeat (3) begin
      applyStimulus(0, 1, 0, 0, 5);
      applyStimulus(0, 0, 0, 0, 5);
    end
    checkOutput("tapIncMin", 10'(incMinCnt - snapM), 10'd3);
    checkOutput("tapIncHour", 10'(incHourCnt - snapH), 10'd0);

    pressMode();
    pressMode();
    checkOutput("holdEntryMode", {8'd0, SET_MODE}, 10'd1);
    snap();
    applyStimulus(0, 1, 0, 0, 2);
    repeat (14) begin
      applyStimulus(0, 1, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 1);
    end
    checkOutput("holdBlank", {6'd0, BLANK}, 10'd0);
    applyStimulus(0, 1, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("holdIncHour", 10'(incHourCnt - snapH), 10'd5);
    checkOutput("holdIncMin", 10'(incMinCnt - snapM), 10'd0);

    pressMode();
    pressMode();
    pressMode();
    repeat (4) begin
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkOutput("blinkOn", {6'd0, BLANK}, 10'b1100);
    repeat (4) begin
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkOutput("blinkOff", {6'd0, BLANK}, 10'b0000);
    snap();
    repeat (9) begin
      applyStimulus(0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 3);
    end
    checkOutput("nineSecStillSet", {8'd0, SET_MODE}, 10'd1);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("timeoutRun", {7'd0, RUN_EN, SET_MODE}, 10'b100);
    checkOutput("timeoutNoClear", 10'(clearCnt - snapC), 10'd0);
    checkOutput("clearAlwaysWithRun", 10'(clearNoRun), 10'd0);

    pressMode();
    snap();
    applyStimulus(1, 1, 0, 0, 3);
    checkOutput("modeBeatsUp", {8'd0, SET_MODE}, 10'd2);
    checkOutput("modeBeatsUpNoInc", 10'((incHourCnt - snapH) + (incMinCnt - snapM)), 10'd0);
    applyStimulus(0, 0, 0, 0, 3);

    snap();
    UP_BUTTON = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("asyncReset", dutVec, 10'b1_000_00_0000);
    repeat (2) step();
    RESET = 1'b1;
    applyStimulus(0, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("postResetNoInc", 10'((incHourCnt - snapH) + (incMinCnt - snapM)), 10'd0);
    checkOutput("postResetState", dutVec, 10'b1_000_00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-setting sequencer for the 24-hour 7-segment clock: converts debounced MODE/UP buttons into field-select state, single-cycle increment strobes for the hour and minute counters, a seconds-clear strobe, and a digit-blink mask for the display multiplexer.
- Sits between the button debouncers / time-base divider and the BCD time counters and scan/display logic.
- Replaces the free-running "hold button to fast-adjust" scheme with an explicit RUN / SET_HOUR / SET_MIN state machine.

Parameters:
- HOLD_TICKS, 8: FAST_TICK strobes UP must stay held before auto-repeat starts.
- REPEAT_TICKS, 2: FAST_TICK strobes between auto-repeat increments.
- BLINK_TICKS, 4: FAST_TICK strobes per blink half-period.
- TIMEOUT_S, 10: SEC_TICK strobes with no button edge before a SET state aborts to RUN.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- SEC_TICK  in  1  one-CLK strobe per second from the time base.
- FAST_TICK  in  1  one-CLK strobe at 8 Hz from the time base.
- MODE_BUTTON  in  1  debounced, CLK-synchronous level, active-high.
- UP_BUTTON  in  1  debounced, CLK-synchronous level, active-high.
- RUN_EN  out  1  1 = seconds counter may count; 0 while setting.
- INC_HOUR  out  1  one-CLK increment strobe to the hour counter.
- INC_MIN  out  1  one-CLK increment strobe to the minute counter.
- CLEAR_SEC  out  1  one-CLK strobe forcing seconds to 00.
- SET_MODE  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven).
- BLANK  out  4  per-digit blank, bit order matching ENABLE[4:1]; 1 = blank digit.

Behaviour:
- Reset (RESET=0, async):
  - state RUN; RUN_EN=1; INC_HOUR, INC_MIN, CLEAR_SEC = 0; SET_MODE=00; BLANK=0000.
  - All counters 0; blink phase 0.
  - Button history registers reset to 1, so a button already held at reset release produces no edge.
- Edge detect: rise_X = X_BUTTON & ~X_q, where X_q is the previous-cycle sample. All outputs are registered: an edge sampled at posedge k drives its output during cycle k+1.
- FSM:
  - RUN, rise_MODE -> SET_HOUR. UP is ignored in RUN.
  - SET_HOUR, rise_MODE -> SET_MIN.
  - SET_MIN, rise_MODE -> RUN, with CLEAR_SEC=1 for exactly one cycle, in the same cycle RUN_EN returns to 1.
  - SET_HOUR or SET_MIN, timeout -> RUN. No CLEAR_SEC on timeout; seconds resume from the held value.
- RUN_EN = 1 only in RUN. SET_MODE reflects the state, registered.
- Increment:
  - In a SET state, rise_UP -> one pulse on INC_HOUR (SET_HOUR) or INC_MIN (SET_MIN).
  - The counters own their wrap (23->00, 59->00); this block never inspects time values.
- Auto-repeat:
  - hold_cnt counts FAST_TICK while UP is held; it clears when UP=0 or on a state change.
  - When hold_cnt reaches HOLD_TICKS, emit a pulse, then one further pulse every REPEAT_TICKS FAST_TICK strobes while UP is held.
  - At most one INC pulse per CLK.
- Blink:
  - blink_cnt counts FAST_TICK; it toggles the phase and clears at BLINK_TICKS.
  - SET_HOUR: BLANK = {phase,phase,0,0}. SET_MIN: BLANK = {0,0,phase,phase}. RUN: 0000.
  - While UP is held, phase is forced to 0 (field stays visible during adjustment).
  - On entry to any SET state, blink_cnt = 0 and phase = 0.
- Timeout:
  - idle_cnt counts SEC_TICK in SET states and saturates at TIMEOUT_S.
  - It clears on rise_MODE, on rise_UP, on every auto-repeat pulse, and on entry to a SET state.
  - Reaching TIMEOUT_S forces RUN on the next cycle.
- Simultaneous events:
  - rise_MODE and rise_UP in the same cycle: MODE wins; no INC pulse; state advances.
  - Timeout and rise_MODE in the same cycle: the MODE transition wins and idle_cnt clears.
  - SEC_TICK and FAST_TICK in the same cycle: both are counted.
- Reset mid-SET: returns to RUN immediately; no pending INC or CLEAR_SEC is emitted after release.
- Counter widths: sized by clog2(parameter+1) per counter; no counter may wrap past its terminal value.

Test Plan:
- Reset with MODE_BUTTON held high, release RESET -> SET_MODE stays 00, RUN_EN=1, no state change until MODE drops and rises again.
- Three MODE presses 20 cycles apart -> SET_MODE 01, 10, 00. CLEAR_SEC high exactly one cycle, coincident with RUN_EN rising. RUN_EN=0 throughout the SET states.
- In SET_MIN, tap UP three times (each 5 cycles high, no FAST_TICK during) -> exactly 3 INC_MIN pulses, each one cycle after the rising edge. INC_HOUR stays 0.
- In SET_HOUR, hold UP across 14 FAST_TICK strobes -> 1 pulse at the edge, 1 at tick 8, then pulses at ticks 10, 12, 14: total 5 INC_HOUR. BLANK stays 0000 while held.
- Enter SET_HOUR and apply 10 SEC_TICK strobes with no button activity -> return to RUN. CLEAR_SEC never asserted. BLANK toggles 1100/0000 every 4 FAST_TICK before the timeout.
- In SET_HOUR, raise MODE and UP in the same cycle -> SET_MODE goes to 10 and no INC pulse occurs. Then assert RESET mid-SET_MIN -> all outputs return to reset values asynchronously.
